qspi_psram_responder: RTL and testbench

Synthesizable QSPI/QPI PSRAM responder that answers the quad-mode PSRAM interface driven by the keyword-spotting accelerator (psram_sck, psram_ce_n, psram_d, psram_douten). It oversamples the bus on the system clock and serves quad fast-read (0xEB) and quad write (0x38) from an internal byte array. It is used as the memory-side model in the FPGA prototype and in closed-loop accelerator simulations, replacing the external PSRAM die.

---
 rtl/qspi_psram_responder.sv | 206 ++++++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_responder.sv
// -----------------------------------------------------------------------------
// qspi_psram_responder
//   Quad-mode PSRAM stand-in. Oversamples the initiator's QSPI bus on clk and
//   serves quad fast-read (0xEB) and quad write (0x38) from an internal byte
//   array of 2^ADDR_BITS bytes (ADDR_BITS in 5..24).
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   psram_sck      bus clock from the initiator (phases >= 3 clk)
//   psram_ce_n     chip enable, active low
//   psram_d_i      nibble driven by the initiator
//   psram_douten   initiator output enables (contention checking only)
//   psram_d_o      nibble driven by the responder
//   psram_d_oe     responder output enables, 4'hF during read data
//   busy           transaction in progress
//   contention     sticky: both sides drove the bus in the same clk
// -----------------------------------------------------------------------------
module qspi_psram_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psram_sck,
    input  logic       psram_ce_n,
    input  logic [3:0] psram_d_i,
    input  logic [3:0] psram_douten,
    output logic [3:0] psram_d_o,
    output logic [3:0] psram_d_oe,
    output logic       busy,
    output logic       contention
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [7:0]           mem [2**ADDR_BITS];

    logic                 sck_r, sck_prev_r, ce_n_r;
    logic [3:0]           d_r;
    logic                 rise_s, fall_s;
    state_t               state_r, state_next_s;
    logic [7:0]           cnt_r;
    logic [3:0]           cmd_r;
    logic                 is_read_r;
    logic [ADDR_BITS-1:0] ptr_r;
    logic                 nib_hi_r;
    logic [3:0]           wr_hi_r;
    logic [7:0]           mem_rd_s;
    logic                 mem_we_s;
    logic [3:0]           d_o_r, d_oe_r;
    logic                 busy_r, contention_r;

    assign rise_s     = sck_r & ~sck_prev_r;
    assign fall_s     = ~sck_r & sck_prev_r;
    assign mem_rd_s   = mem[ptr_r];
    assign mem_we_s   = ~rst & ~ce_n_r & rise_s & ~nib_hi_r & (state_r == ST_WDATA);

    assign psram_d_o  = d_o_r;
    assign psram_d_oe = d_oe_r;
    assign busy       = busy_r;
    assign contention = contention_r;

    // Next-state logic; a high registered ce_n overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (ce_n_r) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_CMD;
                ST_CMD: begin
                    if (rise_s && (cnt_r == 8'd1)) begin
                        if (({cmd_r, d_r} == 8'hEB) || ({cmd_r, d_r} == 8'h38)) begin
                            state_next_s = ST_ADDR;
                        end else begin
                            state_next_s = ST_IGNORE;
                        end
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (rise_s && (cnt_r == 8'd5)) begin
                        if (!is_read_r) begin
                            state_next_s = ST_WDATA;
                        end else if (WAIT_CYCLES == 0) begin
                            state_next_s = ST_RDATA;
                        end else begin
                            state_next_s = ST_WAIT;
                        end
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_WAIT: begin
                    if (rise_s && (cnt_r == WAIT_LAST)) begin
                        state_next_s = ST_RDATA;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                default: state_next_s = state_r;
            endcase
        end
    end

    // Input sampling, state register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_r        <= 1'b0;
            sck_prev_r   <= 1'b0;
            ce_n_r       <= 1'b1;   // idle-bus value, so no spurious frame after reset
            d_r          <= 4'h0;
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            cmd_r        <= 4'h0;
            is_read_r    <= 1'b0;
            ptr_r        <= '0;
            nib_hi_r     <= 1'b1;
            wr_hi_r      <= 4'h0;
            d_o_r        <= 4'h0;
            d_oe_r       <= 4'h0;
            busy_r       <= 1'b0;
            contention_r <= 1'b0;
        end else begin
            sck_r        <= psram_sck;
            sck_prev_r   <= sck_r;
            ce_n_r       <= psram_ce_n;
            d_r          <= psram_d_i;
            state_r      <= state_next_s;
            d_oe_r       <= (state_next_s == ST_RDATA) ? 4'hF : 4'h0;
            busy_r       <= (state_next_s != ST_IDLE);
            contention_r <= contention_r | ((|d_oe_r) & (|psram_douten));

            if (ce_n_r || (state_r == ST_IDLE)) begin
                cnt_r    <= 8'd0;
                nib_hi_r <= 1'b1;
            end else if (rise_s) begin
                case (state_r)
                    ST_CMD: begin
                        cmd_r <= d_r;
                        if (cnt_r == 8'd1) begin
                            is_read_r <= ({cmd_r, d_r} == 8'hEB);
                            cnt_r     <= 8'd0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    ST_ADDR: begin
                        // The pointer itself is the address shift register;
                        // after 6 nibbles only the low ADDR_BITS bits remain.
                        ptr_r <= {ptr_r[ADDR_BITS-5:0], d_r};
                        if (cnt_r == 8'd5) begin
                            cnt_r    <= 8'd0;
                            nib_hi_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_r == WAIT_LAST) begin
                            cnt_r    <= 8'd0;
                            nib_hi_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    ST_WDATA: begin
                        if (nib_hi_r) begin
                            wr_hi_r  <= d_r;
                            nib_hi_r <= 1'b0;
                        end else begin
                            nib_hi_r <= 1'b1;
                            ptr_r    <= ptr_r + PTR_ONE;
                        end
                    end
                    default: cnt_r <= cnt_r;
                endcase
            end else if (fall_s && (state_r == ST_RDATA)) begin
                if (nib_hi_r) begin
                    d_o_r    <= mem_rd_s[7:4];
                    nib_hi_r <= 1'b0;
                end else begin
                    d_o_r    <= mem_rd_s[3:0];
                    nib_hi_r <= 1'b1;
                    ptr_r    <= ptr_r + PTR_ONE;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Byte array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[ptr_r] <= {wr_hi_r, d_r};
        end
    end

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Directed bench for qspi_psram_responder. A byte-array model predicts read
// data; time windows derived from the pin events predict busy / psram_d_oe /
// contention, which one process compares on every clk.
module tb_qspi_psram_responder;
    localparam int HALF = 4;
    localparam int WAIT_CYCLES = 6;
    localparam int BIG = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       psram_sck = 1'b0;
    logic       psram_ce_n = 1'b1;
    logic [3:0] psram_d_i = 4'h0;
    logic [3:0] psram_douten = 4'h0;
    logic [3:0] psram_d_o, psram_d_oe;
    logic       busy, contention;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int busy_from = BIG, busy_until = BIG, oe_from = BIG, oe_until = BIG;

    logic [7:0] model_mem [1024];
    logic [7:0] rd_bytes [8];
    logic [7:0] wr_buf [8];

    qspi_psram_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst), .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
        .psram_d_i(psram_d_i), .psram_douten(psram_douten),
        .psram_d_o(psram_d_o), .psram_d_oe(psram_d_oe),
        .busy(busy), .contention(contention)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int idx(input logic [23:0] a, input int off);
        return (int'(a) + off) % 1024;
    endfunction

    // One SCK period: set data, low phase, sample responder at the rise, high phase.
    task automatic pulse(input logic [3:0] nib, input bit mark_oe, output logic [3:0] smp);
        psram_d_i = nib;
        clk_n(HALF);
        smp = psram_d_o;
        psram_sck = 1'b1;
        if (mark_oe) oe_from = cyc + 2;
        clk_n(HALF);
        psram_sck = 1'b0;
    endtask

    task automatic start_frame();
        oe_from = BIG;
        oe_until = BIG;
        psram_ce_n = 1'b0;
        busy_from = cyc + 2;
        busy_until = BIG;
    endtask

    task automatic end_frame();
        clk_n(HALF);
        psram_ce_n = 1'b1;
        psram_douten = 4'h0;
        busy_until = cyc + 2;
        oe_until = cyc + 2;
        clk_n(HALF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        psram_ce_n = 1'b1;
        psram_sck = 1'b0;
        psram_douten = 4'h0;
        busy_until = cyc + 1;
        oe_until = cyc + 1;
        clk_n(1);
        chk("rst_oe", 32'(psram_d_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_contention", 32'(contention), 32'h0);
        chk("rst_d_o", 32'(psram_d_o), 32'h0);
        clk_n(1);
        rst = 1'b0;
        clk_n(2);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] smp;
        pulse(cmd[7:4], 1'b0, smp);
        pulse(cmd[3:0], 1'b0, smp);
        for (int i = 0; i < 6; i++) pulse(addr[23 - 4*i -: 4], 1'b0, smp);
    endtask

    task automatic read_burst(input logic [23:0] addr, input int n, input bit hold_dout, input bit rst_mid);
        logic [3:0] smp;
        logic [7:0] b;
        logic [3:0] e;
        start_frame();
        psram_douten = 4'hF;
        send_hdr(8'hEB, addr);
        if (!hold_dout) psram_douten = 4'h0;
        for (int i = 0; i < WAIT_CYCLES; i++) pulse(4'h0, (i == WAIT_CYCLES - 1), smp);
        for (int i = 0; i < 2*n; i++) begin
            pulse(4'h0, 1'b0, smp);
            b = model_mem[idx(addr, i/2)];
            e = (i % 2 == 0) ? b[7:4] : b[3:0];
            chk("rd_nibble", 32'(smp), 32'(e));
            if (i % 2 == 0) rd_bytes[i/2][7:4] = smp;
            else            rd_bytes[i/2][3:0] = smp;
        end
        if (rst_mid) do_reset();
        else         end_frame();
    endtask

    task automatic write_burst(input logic [23:0] addr, input int n, input bit abort_hi);
        logic [3:0] smp;
        start_frame();
        psram_douten = 4'hF;
        send_hdr(8'h38, addr);
        for (int k = 0; k < n; k++) begin
            pulse(wr_buf[k][7:4], 1'b0, smp);
            if (!(abort_hi && k == n - 1)) begin
                pulse(wr_buf[k][3:0], 1'b0, smp);
                model_mem[idx(addr, k)] = wr_buf[k];
            end
        end
        end_frame();
    endtask

    task automatic ignore_frame();
        logic [3:0] smp;
        start_frame();
        psram_douten = 4'hF;
        pulse(4'h9, 1'b0, smp);
        pulse(4'hF, 1'b0, smp);
        for (int i = 0; i < 20; i++) pulse(4'($urandom_range(0, 15)), 1'b0, smp);
        end_frame();
    endtask

    // Per-clk comparison of busy / psram_d_oe / contention against the event windows.
    initial begin
        logic [3:0] e_oe, prev_oe;
        logic       e_busy, e_cont;
        prev_oe = 4'h0;
        e_cont = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                e_cont = 1'b0;
                prev_oe = 4'h0;
                chk("oe_in_reset", 32'(psram_d_oe), 32'h0);
                chk("busy_in_reset", 32'(busy), 32'h0);
                chk("cont_in_reset", 32'(contention), 32'h0);
            end else begin
                e_cont = e_cont | ((prev_oe != 4'h0) && (psram_douten != 4'h0));
                e_oe = (cyc >= oe_from && cyc < oe_until) ? 4'hF : 4'h0;
                e_busy = (cyc >= busy_from && cyc < busy_until);
                chk("oe", 32'(psram_d_oe), 32'(e_oe));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("contention", 32'(contention), 32'(e_cont));
                prev_oe = e_oe;
            end
        end
    end

    initial begin
        clk_n(3);
        rst = 1'b0;
        clk_n(2);
        chk("reset_oe", 32'(psram_d_oe), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_d_o", 32'(psram_d_o), 32'h0);

        // Quad write then read.
        wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
        write_burst(24'h000010, 2, 1'b0);
        read_burst(24'h000010, 2, 1'b0, 1'b0);
        chk("wr_rd_byte0", 32'(rd_bytes[0]), 32'hA5);
        chk("wr_rd_byte1", 32'(rd_bytes[1]), 32'h3C);

        // Wrap-around and address aliasing.
        wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
        write_burst(24'h0003FF, 2, 1'b0);
        read_burst(24'h0003FF, 2, 1'b0, 1'b0);
        chk("wrap_byte0", 32'(rd_bytes[0]), 32'h11);
        chk("wrap_byte1", 32'(rd_bytes[1]), 32'h22);
        read_burst(24'hFFFC00, 1, 1'b0, 1'b0);
        chk("alias_byte", 32'(rd_bytes[0]), 32'h22);

        // Aborted write: first byte lands, second target untouched.
        wr_buf[0] = 8'h77; wr_buf[1] = 8'h88;
        write_burst(24'h000020, 2, 1'b0);
        wr_buf[0] = 8'h5A; wr_buf[1] = 8'hC3;
        write_burst(24'h000020, 2, 1'b1);
        chk("abort_idle", 32'(busy), 32'h0);
        read_burst(24'h000020, 2, 1'b0, 1'b0);
        chk("abort_byte0", 32'(rd_bytes[0]), 32'h5A);
        chk("abort_byte1", 32'(rd_bytes[1]), 32'h88);

        // Unknown command, then a normal read.
        ignore_frame();
        read_burst(24'h000010, 2, 1'b0, 1'b0);
        chk("ignore_byte0", 32'(rd_bytes[0]), 32'hA5);
        chk("ignore_byte1", 32'(rd_bytes[1]), 32'h3C);

        // Reset in the middle of a read, then an immediate read.
        read_burst(24'h000010, 1, 1'b0, 1'b1);
        read_burst(24'h000010, 2, 1'b0, 1'b0);
        chk("post_rst_byte0", 32'(rd_bytes[0]), 32'hA5);
        chk("post_rst_byte1", 32'(rd_bytes[1]), 32'h3C);

        // Contention: initiator keeps driving into the data phase.
        read_burst(24'h0003FF, 1, 1'b1, 1'b0);
        chk("cont_set", 32'(contention), 32'h1);
        clk_n(5);
        chk("cont_sticky", 32'(contention), 32'h1);
        do_reset();
        chk("cont_cleared", 32'(contention), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
